n64_input_events: RTL and testbench

N64_INPUT_EVENTS -- requirements
Module: n64_input_events

---
 rtl/n64_pkg.sv | 60 ++++++
 rtl/n64_evt_fifo.sv | 55 +++++
 rtl/n64_input_events.sv | 182 ++++++++++++++++++
 tb/tb_n64_input_events.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/n64_pkg.sv
// Shared definitions for the N64 controller event generator: event word
// layout, class codes, frame bit positions and the FSM state type.
package n64_pkg;

  // Event classes carried in the class field of an event word
  localparam logic [1:0] CLASS_BUTTON = 2'b00;
  localparam logic [1:0] CLASS_STICK  = 2'b01;
  localparam logic [1:0] CLASS_LINK   = 2'b10;

  // Bit positions inside the 8-bit event word
  localparam int EVT_PRESS_BIT = 7;
  localparam int EVT_CLASS_MSB = 6;
  localparam int EVT_CLASS_LSB = 5;
  localparam int EVT_RSVD_BIT  = 4;
  localparam int EVT_INDEX_MSB = 3;
  localparam int EVT_INDEX_LSB = 0;

  // Logical item counts: 14 buttons followed by 4 stick directions
  localparam int NUM_BUTTONS = 14;
  localparam int NUM_STICK   = 4;
  localparam int NUM_ITEMS   = NUM_BUTTONS + NUM_STICK;
  localparam int FRAME_W     = 34;

  // Frame bit carrying each logical button index (A, B, Z, Start, Up, Down,
  // Left, Right, L, R, C-Up, C-Down, C-Left, C-Right)
  localparam int BTN_BIT [NUM_BUTTONS] = '{1, 2, 3, 4, 5, 6, 7, 8,
                                           11, 12, 13, 14, 15, 16};

  // Axis fields in the frame; the lower frame bit holds the axis MSB
  localparam int X_FIELD_LO = 17;
  localparam int X_FIELD_HI = 24;
  localparam int Y_FIELD_LO = 25;
  localparam int Y_FIELD_HI = 32;

  typedef enum logic [1:0] {
    IDLE,
    LINKEV,
    SCAN
  } state_t;

  // Assemble an event word from its fields; the reserved bit stays zero
  function automatic logic [7:0] make_event(input logic       press,
                                            input logic [1:0] cls,
                                            input logic [3:0] idx);
    logic [7:0] w;
    w = '0;
    w[EVT_PRESS_BIT]                 = press;
    w[EVT_CLASS_MSB:EVT_CLASS_LSB]   = cls;
    w[EVT_INDEX_MSB:EVT_INDEX_LSB]   = idx;
    return w;
  endfunction

  // Axis bytes arrive MSB-first, so the raw field is bit-reversed
  function automatic logic signed [7:0] axis_decode(input logic [7:0] field);
    logic signed [7:0] v;
    v = {<<{field}};
    return v;
  endfunction

endpackage

// File: rtl/n64_evt_fifo.sv
// Show-ahead event FIFO. A push into a full FIFO is refused even when a pop
// happens in the same cycle; the head reads as zero while empty.
module n64_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_50MHZ,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are only meaningful between the pointers
  always_ff @(posedge clk_50MHZ) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_50MHZ or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/n64_input_events.sv
// Turns N64 controller frames into press/release/link events. Each new frame
// is snapshotted, then scanned one item per cycle against the held state.
module n64_input_events
  import n64_pkg::*;
#(
  parameter int DEADZONE     = 16,
  parameter int LINK_TIMEOUT = 2500000,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clk_50MHZ,
  input  logic                 reset,
  input  logic [FRAME_W-1:0]   buttons,
  input  logic                 alive,
  output logic                 evt_valid,
  output logic [7:0]           evt_data,
  input  logic                 evt_ready,
  output logic [NUM_ITEMS-1:0] held,
  output logic                 link_up,
  output logic [7:0]           drop_cnt
);

  localparam int TW = $clog2(LINK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LIMIT   = TW'(LINK_TIMEOUT);
  localparam logic [4:0]    FIRST_STICK = 5'(NUM_BUTTONS);
  localparam logic [4:0]    LAST_ITEM   = 5'(NUM_ITEMS - 1);

  state_t               state, state_d;
  logic                 alive_meta, alive_sync, alive_prev;
  logic                 frame_edge;
  logic [TW-1:0]        tmo_cnt;
  logic                 timeout;
  logic [NUM_ITEMS-1:0] frame_state;
  logic [NUM_ITEMS-1:0] snapshot;
  logic [NUM_ITEMS-1:0] held_q;
  logic [4:0]           scan_idx;
  logic                 link_q;
  logic [7:0]           drop_q;
  logic signed [7:0]    x_axis, y_axis;
  logic                 unused_frame_bits;
  logic                 item_new, item_changed, item_is_stick;
  logic [3:0]           item_index;
  logic                 fifo_push, fifo_full, fifo_empty;
  logic [7:0]           push_data;
  logic                 snap_load, snap_clear, idx_clr, idx_inc, held_wr;
  logic                 link_set, link_clr, drop;

  // Decode the live frame into the 18 logical items
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    assign frame_state[i] = buttons[BTN_BIT[i]];
  end
  assign x_axis = axis_decode(buttons[X_FIELD_HI:X_FIELD_LO]);
  assign y_axis = axis_decode(buttons[Y_FIELD_HI:Y_FIELD_LO]);
  assign frame_state[NUM_BUTTONS + 0] = int'(x_axis) < -DEADZONE;
  assign frame_state[NUM_BUTTONS + 1] = int'(x_axis) > DEADZONE;
  assign frame_state[NUM_BUTTONS + 2] = int'(y_axis) < -DEADZONE;
  assign frame_state[NUM_BUTTONS + 3] = int'(y_axis) > DEADZONE;
  assign unused_frame_bits = ^{buttons[0], buttons[10:9], buttons[33]};

  assign frame_edge    = alive_sync ^ alive_prev;
  assign timeout       = link_q && (tmo_cnt == TMO_LIMIT);
  assign item_new      = snapshot[scan_idx];
  assign item_changed  = item_new != held_q[scan_idx];
  assign item_is_stick = scan_idx >= FIRST_STICK;
  assign item_index    = item_is_stick ? 4'(scan_idx - FIRST_STICK) : scan_idx[3:0];

  assign held     = held_q;
  assign link_up  = link_q;
  assign drop_cnt = drop_q;
  assign evt_valid = !fifo_empty;

  // Two-flop synchronizer plus the previous sample used for edge detection
  always_ff @(posedge clk_50MHZ or posedge reset) begin
    if (reset) begin
      alive_meta <= 1'b0;
      alive_sync <= 1'b0;
      alive_prev <= 1'b0;
    end else begin
      alive_meta <= alive;
      alive_sync <= alive_meta;
      alive_prev <= alive_sync;
    end
  end

  // Link watchdog: restarts on any frame, idles while down, holds at the limit
  always_ff @(posedge clk_50MHZ or posedge reset) begin
    if (reset)                   tmo_cnt <= '0;
    else if (frame_edge)         tmo_cnt <= '0;
    else if (!link_q)            tmo_cnt <= '0;
    else if (tmo_cnt != TMO_LIMIT) tmo_cnt <= tmo_cnt + TW'(1);
  end

  // FSM state register
  always_ff @(posedge clk_50MHZ or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next state and datapath controls; a full FIFO stalls the current item
  always_comb begin
    state_d    = state;
    fifo_push  = 1'b0;
    push_data  = '0;
    snap_load  = 1'b0;
    snap_clear = 1'b0;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    held_wr    = 1'b0;
    link_set   = 1'b0;
    link_clr   = 1'b0;
    drop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_edge) begin
          snap_load = 1'b1;
          idx_clr   = 1'b1;
          state_d   = link_q ? SCAN : LINKEV;
        end else if (timeout) begin
          snap_clear = 1'b1;
          idx_clr    = 1'b1;
          state_d    = LINKEV;
        end
      end
      LINKEV: begin
        drop      = frame_edge;
        push_data = make_event(!link_q, CLASS_LINK, 4'd0);
        if (!fifo_full) begin
          fifo_push = 1'b1;
          link_set  = !link_q;
          link_clr  = link_q;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        drop      = frame_edge;
        push_data = make_event(item_new, item_is_stick ? CLASS_STICK : CLASS_BUTTON,
                               item_index);
        if (!item_changed || !fifo_full) begin
          fifo_push = item_changed;
          held_wr   = item_changed;
          if (scan_idx == LAST_ITEM) state_d = IDLE;
          else                       idx_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Snapshot, scan position, held state, link flag and drop counter
  always_ff @(posedge clk_50MHZ or posedge reset) begin
    if (reset) begin
      snapshot <= '0;
      scan_idx <= '0;
      held_q   <= '0;
      link_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      if (snap_load)       snapshot <= frame_state;
      else if (snap_clear) snapshot <= '0;
      if (idx_clr)         scan_idx <= '0;
      else if (idx_inc)    scan_idx <= scan_idx + 5'd1;
      if (held_wr)         held_q[scan_idx] <= item_new;
      if (link_set)        link_q <= 1'b1;
      else if (link_clr)   link_q <= 1'b0;
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  n64_evt_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_50MHZ (clk_50MHZ),
    .reset     (reset),
    .push      (fifo_push),
    .din       (push_data),
    .full      (fifo_full),
    .pop       (evt_valid && evt_ready),
    .dout      (evt_data),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_n64_input_events.sv
// Bench for n64_input_events: directed scenarios plus random frames, checked
// against an event-level model of the controller's logical state.
module tb_n64_input_events;

  localparam int DZ = 16;
  localparam int LT = 400;
  localparam int FD = 8;

  logic        clk_50MHZ = 1'b0;
  logic        reset;
  logic [33:0] buttons;
  logic        alive;
  logic        evt_valid;
  logic [7:0]  evt_data;
  logic        evt_ready;
  logic [17:0] held;
  logic        link_up;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [17:0] model_held;
  logic        model_link;

  localparam int BTN_FRAME_BIT [14] = '{1, 2, 3, 4, 5, 6, 7, 8, 11, 12, 13, 14, 15, 16};

  always #10 clk_50MHZ = ~clk_50MHZ;

  n64_input_events #(
    .DEADZONE     (DZ),
    .LINK_TIMEOUT (LT),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk_50MHZ (clk_50MHZ),
    .reset     (reset),
    .buttons   (buttons),
    .alive     (alive),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .evt_ready (evt_ready),
    .held      (held),
    .link_up   (link_up),
    .drop_cnt  (drop_cnt)
  );

  // Record every accepted event, sampled half a cycle before the pop edge
  always @(negedge clk_50MHZ) begin
    if (!reset && evt_valid && evt_ready) got_q.push_back(evt_data);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50MHZ);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int axis_value(input logic [33:0] f, input int msb_bit);
    int v;
    v = 0;
    for (int k = 0; k < 8; k++) v = v * 2 + int'(f[msb_bit + k]);
    if (v >= 128) v = v - 256;
    return v;
  endfunction

  function automatic logic [33:0] with_axes(input logic [33:0] f, input int x, input int y);
    logic [33:0] r;
    int          xb, yb;
    r  = f;
    xb = x & 255;
    yb = y & 255;
    for (int k = 0; k < 8; k++) begin
      r[17 + k] = ((xb >> (7 - k)) & 1) != 0;
      r[25 + k] = ((yb >> (7 - k)) & 1) != 0;
    end
    return r;
  endfunction

  task automatic model_frame(input logic [33:0] f);
    logic [17:0] nv;
    int          x, y, code;
    if (!model_link) begin
      exp_q.push_back(8'hC0);
      model_link = 1'b1;
    end
    for (int i = 0; i < 14; i++) nv[i] = f[BTN_FRAME_BIT[i]];
    x = axis_value(f, 17);
    y = axis_value(f, 25);
    nv[14] = x < -DZ;
    nv[15] = x > DZ;
    nv[16] = y < -DZ;
    nv[17] = y > DZ;
    for (int i = 0; i < 18; i++) begin
      if (nv[i] != model_held[i]) begin
        code = (nv[i] ? 128 : 0) + ((i < 14) ? i : 32 + (i - 14));
        exp_q.push_back(8'(code));
      end
    end
    model_held = nv;
  endtask

  task automatic model_timeout();
    exp_q.push_back(8'h40);
    model_link = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (model_held[i]) exp_q.push_back(8'((i < 14) ? i : 32 + (i - 14)));
    end
    model_held = '0;
  endtask

  task automatic applyStimulus(input logic [33:0] f);
    buttons = f;
    alive   = ~alive;
  endtask

  task automatic drain_and_check(input string tag, input int bound, input bit rand_ready);
    int waited;
    int n;
    waited = 0;
    while (got_q.size() < exp_q.size() && waited < bound) begin
      if (rand_ready) evt_ready = 1'($urandom_range(0, 1));
      tick(1);
      waited++;
    end
    evt_ready = 1'b1;
    tick(30);
    checkOutput({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s evt%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    checkOutput({tag, " held"}, 32'(held), 32'(model_held));
    checkOutput({tag, " link_up"}, 32'(link_up), 32'(model_link));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [33:0] f;
    logic [63:0] r;
    int          lat;
    int          picks [8];

    picks = '{16, 17, -16, -17, 0, 127, -128, 5};
    reset = 1'b1;
    alive = 1'b0;
    buttons = '0;
    evt_ready = 1'b0;
    model_held = '0;
    model_link = 1'b0;
    tick(3);
    checkOutput("reset evt_valid", 32'(evt_valid), 0);
    checkOutput("reset evt_data", 32'(evt_data), 0);
    checkOutput("reset held", 32'(held), 0);
    checkOutput("reset link_up", 32'(link_up), 0);
    checkOutput("reset drop_cnt", 32'(drop_cnt), 0);
    reset = 1'b0;
    tick(2);

    $display("[TB] scenario 1: first frame brings link up");
    evt_ready = 1'b1;
    f = '0;
    f[1] = 1'b1;
    model_frame(f);
    applyStimulus(f);
    lat = 0;
    while (!evt_valid && lat < 20) begin
      tick(1);
      lat++;
    end
    checkOutput("s1 first event within 6 cycles", 32'(lat <= 6), 1);
    drain_and_check("s1", 200, 1'b0);

    $display("[TB] scenario 2: release, then identical frame");
    f = '0;
    model_frame(f);
    applyStimulus(f);
    drain_and_check("s2", 200, 1'b0);
    model_frame(f);
    applyStimulus(f);
    drain_and_check("s2 repeat", 200, 1'b0);

    $display("[TB] scenario 3: stick deadzone");
    f = with_axes('0, 'h10, 0);
    model_frame(f);
    applyStimulus(f);
    drain_and_check("s3 x=16", 200, 1'b0);
    f = with_axes('0, 'h11, 0);
    model_frame(f);
    applyStimulus(f);
    drain_and_check("s3 x=17", 200, 1'b0);
    f = with_axes('0, 'hEF, 0);
    model_frame(f);
    applyStimulus(f);
    drain_and_check("s3 x=-17", 200, 1'b0);

    $display("[TB] scenario 4: backpressure and dropped frame");
    evt_ready = 1'b0;
    f = with_axes('0, 'hEF, 0);
    for (int i = 0; i < 10; i++) f[BTN_FRAME_BIT[i]] = 1'b1;
    model_frame(f);
    applyStimulus(f);
    tick(40);
    checkOutput("s4 stalled evt_valid", 32'(evt_valid), 1);
    checkOutput("s4 nothing popped", 32'(got_q.size()), 0);
    applyStimulus(f);
    tick(10);
    checkOutput("s4 drop_cnt", 32'(drop_cnt), 1);
    evt_ready = 1'b1;
    drain_and_check("s4", 200, 1'b0);

    $display("[TB] scenario 5: link timeout");
    f = '0;
    f[2] = 1'b1;
    model_frame(f);
    applyStimulus(f);
    drain_and_check("s5 hold B", 200, 1'b0);
    model_timeout();
    drain_and_check("s5 timeout", LT + 200, 1'b0);

    $display("[TB] scenario 6: reset during scan");
    evt_ready = 1'b0;
    f = '0;
    f[1] = 1'b1;
    applyStimulus(f);
    tick(8);
    reset = 1'b1;
    #1;
    checkOutput("s6 evt_valid in reset", 32'(evt_valid), 0);
    checkOutput("s6 held in reset", 32'(held), 0);
    checkOutput("s6 drop_cnt in reset", 32'(drop_cnt), 0);
    checkOutput("s6 link_up in reset", 32'(link_up), 0);
    alive = 1'b0;
    tick(2);
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    model_held = '0;
    model_link = 1'b0;
    tick(3);
    evt_ready = 1'b1;
    model_frame(f);
    applyStimulus(f);
    drain_and_check("s6 after reset", 200, 1'b0);

    $display("[TB] random frames with random consumer stalls");
    for (int n = 0; n < 15; n++) begin
      r = {$urandom(), $urandom()};
      f = r[33:0];
      f = with_axes(f,
                    (n % 3 == 2) ? int'($urandom_range(0, 255)) : picks[$urandom_range(0, 7)],
                    (n % 3 == 1) ? int'($urandom_range(0, 255)) : picks[$urandom_range(0, 7)]);
      model_frame(f);
      applyStimulus(f);
      drain_and_check($sformatf("rand%0d", n), 300, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
